mrr_rx_iq_stim_gen: RTL

//  Parametrised AD9361-style receive-interface stimulus generator. It produces the
//  rx_frame/rx_data word stream and a matching per-sample reference for 1 or 2 channels.

---
 rtl/mrr_stim_pkg.sv | 26 ++
 rtl/mrr_stim_lfsr.sv | 22 ++
 rtl/mrr_rx_iq_stim_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mrr_stim_pkg.sv
// Shared types and constants for the rx IQ stimulus generator.
// Pure definitions: no latency and no flow control.
package mrr_stim_pkg;

    localparam int WORDS_PER_CH = 4;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_PRBS   = 2'd2,
        MODE_TOGGLE = 2'd3
    } stim_mode_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // x^15 + x^14 + 1, Fibonacci form: feedback = bit14 ^ bit13
    localparam int PRBS_LEN    = 15;
    localparam int PRBS_TAP_HI = 14;
    localparam int PRBS_TAP_LO = 13;

    localparam logic [31:0] TOGGLE_A = 32'h5555_5555;
    localparam logic [31:0] TOGGLE_B = 32'hAAAA_AAAA;

endpackage

// File: rtl/mrr_stim_lfsr.sv
// PRBS15 generator: state visible immediately, one step per cycle with advance high.
// Latency: next state one clock after advance; no backpressure.
module mrr_stim_lfsr
    import mrr_stim_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = 15'h7FFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance,
    output logic [PRBS_LEN-1:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (advance) begin
            state <= {state[PRBS_LEN-2:0], state[PRBS_TAP_HI] ^ state[PRBS_TAP_LO]};
        end
    end

endmodule

// File: rtl/mrr_rx_iq_stim_gen.sv
// AD9361-style rx_frame/rx_data stimulus generator with per-sample reference output.
// Latency: first word the cycle after start; no backpressure, one word per clock in RUN.
module mrr_rx_iq_stim_gen
    import mrr_stim_pkg::*;
#(
    parameter int                  DATA_WIDTH   = 6,
    parameter int                  SAMPLE_WIDTH = 12,
    parameter int                  NUM_CHANNELS = 1,
    parameter logic [PRBS_LEN-1:0] LFSR_SEED    = 15'h7FFF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_enable,
    input  logic [1:0]                cfg_mode,
    input  logic [2*SAMPLE_WIDTH-1:0] cfg_const,
    input  logic [15:0]               cfg_burst_len,
    input  logic [15:0]               cfg_gap_len,
    input  logic                      start,
    output logic                      rx_frame,
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      rx_valid,
    output logic                      ref_valid,
    output logic                      ref_chan,
    output logic [SAMPLE_WIDTH-1:0]   ref_i,
    output logic [SAMPLE_WIDTH-1:0]   ref_q,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               sample_cnt
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int DW = DATA_WIDTH;

    if (NUM_CHANNELS != 1 && NUM_CHANNELS != 2) begin : g_bad_channels
        $error("NUM_CHANNELS must be 1 or 2");
    end
    if (SW != 2 * DW || SW > PRBS_LEN) begin : g_bad_width
        $error("SAMPLE_WIDTH must equal 2*DATA_WIDTH and not exceed 15");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    logic [1:0]          state, state_n;
    logic [1:0]          word_phase;
    logic                chan;
    logic [15:0]         frame_cnt, gap_cnt, burst_len_q, gap_len_q;
    stim_mode_e          mode_q, eff_mode;
    logic [2*SW-1:0]     const_q, eff_const;
    logic [SW-1:0]       cur_i, cur_q, nxt_i, nxt_q;
    logic [SW-1:0]       ramp_n [2];
    logic                tog_q;
    logic [PRBS_LEN-1:0] lfsr_state;
    logic                lfsr_adv, ramp_adv, tog_adv;
    logic                done_q;
    logic [31:0]         cnt_q;
    logic                run, last_ch, last_frame, burst_end, cont_stop, gap_end;
    logic                load, frame_load, load_chan;

    assign run        = (state == ST_RUN);
    assign last_ch    = run && (word_phase == 2'(WORDS_PER_CH - 1));
    assign last_frame = last_ch && (NUM_CHANNELS == 1 || chan);
    assign burst_end  = last_frame && (burst_len_q != 16'd0) && (frame_cnt == burst_len_q - 16'd1);
    // Continuous mode has no burst end, so every frame boundary is a stop point.
    assign cont_stop  = last_frame && (burst_len_q == 16'd0) && !cfg_enable;
    assign gap_end    = (state == ST_GAP) && (gap_cnt == gap_len_q - 16'd1);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (start && cfg_enable) state_n = ST_RUN;
            ST_RUN: begin
                if (burst_end)
                    state_n = !cfg_enable ? ST_IDLE : ((gap_len_q != 16'd0) ? ST_GAP : ST_RUN);
                else if (cont_stop)
                    state_n = ST_IDLE;
            end
            ST_GAP:  if (gap_end) state_n = cfg_enable ? ST_RUN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // A new channel sample is captured on the edge before its first word.
    assign load       = (state_n == ST_RUN) && (!run || last_ch);
    assign frame_load = load && (!run || last_frame);
    assign load_chan  = !frame_load;
    assign eff_mode   = frame_load ? stim_mode_e'(cfg_mode) : mode_q;
    assign eff_const  = frame_load ? cfg_const : const_q;

    always_comb begin
        nxt_i    = '0;
        nxt_q    = '0;
        lfsr_adv = 1'b0;
        ramp_adv = 1'b0;
        tog_adv  = 1'b0;
        if (load) begin
            case (eff_mode)
                MODE_CONST: begin
                    nxt_i = eff_const[2*SW-1 -: SW];
                    nxt_q = eff_const[SW-1:0];
                end
                MODE_RAMP: begin
                    nxt_i    = ramp_n[load_chan];
                    nxt_q    = ~ramp_n[load_chan];
                    ramp_adv = 1'b1;
                end
                MODE_PRBS: begin
                    nxt_i    = lfsr_state[SW-1:0];
                    nxt_q    = lfsr_state[PRBS_LEN-1 -: SW];
                    lfsr_adv = 1'b1;
                end
                default: begin
                    nxt_i   = tog_q ? TOGGLE_B[SW-1:0] : TOGGLE_A[SW-1:0];
                    nxt_q   = tog_q ? TOGGLE_A[SW-1:0] : TOGGLE_B[SW-1:0];
                    tog_adv = 1'b1;
                end
            endcase
        end
    end

    mrr_stim_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            word_phase  <= '0;
            chan        <= 1'b0;
            frame_cnt   <= '0;
            gap_cnt     <= '0;
            burst_len_q <= '0;
            gap_len_q   <= '0;
            mode_q      <= MODE_CONST;
            const_q     <= '0;
            cur_i       <= '0;
            cur_q       <= '0;
            ramp_n[0]   <= '0;
            ramp_n[1]   <= '0;
            tog_q       <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state   <= state_n;
            done_q  <= burst_end || cont_stop;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 16'd1 : 16'd0;
            if (state == ST_IDLE && state_n == ST_RUN) begin
                burst_len_q <= cfg_burst_len;
                gap_len_q   <= cfg_gap_len;
            end
            if (!run) begin
                word_phase <= '0;
                chan       <= 1'b0;
                frame_cnt  <= '0;
            end else begin
                word_phase <= word_phase + 2'd1;
                if (last_ch)
                    chan <= (NUM_CHANNELS == 2) ? ~chan : 1'b0;
                if (last_frame) begin
                    frame_cnt <= burst_end ? 16'd0 : frame_cnt + 16'd1;
                    cnt_q     <= cnt_q + 32'd1;
                end
            end
            if (frame_load) begin
                mode_q  <= stim_mode_e'(cfg_mode);
                const_q <= cfg_const;
            end
            if (load) begin
                cur_i <= nxt_i;
                cur_q <= nxt_q;
            end
            if (ramp_adv)
                ramp_n[load_chan] <= ramp_n[load_chan] + 1'b1;
            if (tog_adv)
                tog_q <= ~tog_q;
        end
    end

    always_comb begin
        rx_data = '0;
        if (run) begin
            case (word_phase)
                2'd0:    rx_data = cur_i[SW-1 -: DW];
                2'd1:    rx_data = cur_q[SW-1 -: DW];
                2'd2:    rx_data = cur_i[DW-1:0];
                default: rx_data = cur_q[DW-1:0];
            endcase
        end
    end

    assign rx_valid   = run;
    assign rx_frame   = run && ((NUM_CHANNELS == 1) ? !word_phase[1] : !chan);
    assign ref_valid  = run && (word_phase == 2'd0);
    assign ref_chan   = ref_valid && chan;
    assign ref_i      = ref_valid ? cur_i : '0;
    assign ref_q      = ref_valid ? cur_q : '0;
    assign busy       = (state != ST_IDLE);
    assign done       = done_q;
    assign sample_cnt = cnt_q;

endmodule
